// File: rtl/harness_reset_sequencer_if.sv
// Signal bundle between the harness reset sequencer and its environment.
// The sequencer takes the slave view; the environment driving start/abort/kick takes master.
interface harness_reset_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CUR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  // No valid/ready pair: start_i, abort_i and kick_i are level requests sampled on every
  // rising clk edge, so a one-cycle pulse is one request. Every output is registered.
  logic              start_i;
  logic              abort_i;
  logic [NUM_CH-1:0] ch_mask_i;
  logic              kick_i;
  logic [NUM_CH-1:0] ch_rst_n_o;
  logic [CUR_W-1:0]  cur_ch_o;
  logic              busy_o;
  logic              run_o;
  logic              done_o;
  logic              timeout_o;
  logic [2:0]        dbg_state;

  modport master (
    output start_i, abort_i, ch_mask_i, kick_i,
    input  ch_rst_n_o, cur_ch_o, busy_o, run_o, done_o, timeout_o, dbg_state
  );

  modport slave (
    input  start_i, abort_i, ch_mask_i, kick_i,
    output ch_rst_n_o, cur_ch_o, busy_o, run_o, done_o, timeout_o, dbg_state
  );
endinterface

// File: rtl/harness_reset_sequencer.sv
// Ordered per-channel reset release with a kickable run-phase watchdog.
// Optional macro HARNESS_RSTSEQ_WDOG_EN enables the watchdog and the TIMEOUT state.
module harness_reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int WDOG_CYCLES = 1000
) (
  input logic                     clk,
  input logic                     rst_n,
  harness_reset_sequencer_if.slave bus
);

  localparam int CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CUR_W-1:0] LAST_CH   = CUR_W'(NUM_CH - 1);
  localparam logic [CUR_W-1:0] CUR_ONE   = CUR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3
`ifdef HARNESS_RSTSEQ_WDOG_EN
    ,S_TIMEOUT = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CUR_W-1:0]  cur_q, cur_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              done_q, done_d;
  logic              take_start;
  logic              enter_ch;
  logic [CUR_W-1:0]  enter_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      mask_q  <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    done_d     = 1'b0;
    take_start = 1'b0;
    enter_ch   = 1'b0;
    enter_idx  = '0;
    if (bus.abort_i) begin
      // Abort outranks a simultaneous start in every state.
      state_d = S_IDLE;
      cnt_d   = '0;
      cur_d   = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: take_start = bus.start_i;
        S_HOLD: begin
          if (cnt_q == '0) begin
            enter_ch  = 1'b1;
            enter_idx = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_RELEASE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (cur_q == LAST_CH) begin
            state_d = S_RUN;
            done_d  = 1'b1;
            cnt_d   = WDOG_LOAD;
          end else begin
            enter_ch  = 1'b1;
            enter_idx = cur_q + CUR_ONE;
          end
        end
`ifdef HARNESS_RSTSEQ_WDOG_EN
        S_RUN: begin
          // A kick on the terminal count still reloads; expiry needs a silent zero cycle.
          if (bus.kick_i) begin
            cnt_d = WDOG_LOAD;
          end else if (cnt_q == '0) begin
            state_d = S_TIMEOUT;
            ch_d    = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_TIMEOUT: take_start = bus.start_i;
`endif
        default: ;
      endcase

      if (take_start) begin
        state_d = S_HOLD;
        mask_d  = bus.ch_mask_i;
        cnt_d   = HOLD_LOAD;
        cur_d   = '0;
        ch_d    = '0;
      end

      // The released bit is written on the same edge that selects the channel, so the
      // DUT sees its reset lift in the first RELEASE cycle for that channel.
      if (enter_ch) begin
        state_d = S_RELEASE;
        cur_d   = enter_idx;
        if (mask_q[enter_idx]) begin
          ch_d[enter_idx] = 1'b1;
          cnt_d           = GAP_LOAD;
        end else begin
          cnt_d = '0;
        end
      end
    end
  end

  assign bus.ch_rst_n_o = ch_q;
  assign bus.cur_ch_o   = cur_q;
  assign bus.busy_o     = (state_q == S_HOLD) || (state_q == S_RELEASE);
  assign bus.run_o      = (state_q == S_RUN);
  assign bus.done_o     = done_q;
  assign bus.dbg_state  = state_q;

`ifdef HARNESS_RSTSEQ_WDOG_EN
  assign bus.timeout_o = (state_q == S_TIMEOUT);
`else
  logic unused_kick;
  assign unused_kick   = bus.kick_i;
  assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_harness_reset_sequencer.sv
// Scoreboard bench for harness_reset_sequencer: stimulus pushes expected output-change
// events {cycle, state, ch_rst_n, busy, run, done, timeout}; a negedge monitor pops them.
module tb_harness_reset_sequencer;

  localparam int NUM_CH = 4;
  localparam int EW     = 43;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HOLD = 3'd1;
  localparam logic [2:0] ST_REL  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_TO   = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [EW-1:0] exp_q[$];

  harness_reset_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

  harness_reset_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(16), .HOLD_CYCLES(8), .GAP_CYCLES(4), .WDOG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [EW-1:0] ev(input int c, input logic [2:0] st, input logic [3:0] ch,
                                       input logic b, input logic r, input logic d, input logic t);
    logic [31:0] c32;
    c32 = c;
    return {c32, st, ch, b, r, d, t};
  endfunction

  task automatic wait_until(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  // Callers are positioned at a negedge; the request is sampled on the next rising edge.
  task automatic do_start(input logic [3:0] m, output int t);
    bus.start_i   = 1'b1;
    bus.ch_mask_i = m;
    t = cyc;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic do_abort();
    exp_q.push_back(ev(cyc + 1, ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.abort_i = 1'b1;
    @(posedge clk);
    #1 bus.abort_i = 1'b0;
  endtask

  task automatic do_kick();
    bus.kick_i = 1'b1;
    @(posedge clk);
    #1 bus.kick_i = 1'b0;
  endtask

  // All four channels enabled, start sampled at the edge closing cycle t.
  task automatic push_full(input int t);
    exp_q.push_back(ev(t + 1,  ST_HOLD, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 9,  ST_REL,  4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 13, ST_REL,  4'b0011, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 17, ST_REL,  4'b0111, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 21, ST_REL,  4'b1111, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 25, ST_RUN,  4'b1111, 1'b0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(ev(t + 26, ST_RUN,  4'b1111, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [10:0] prev_out = '1;
  always @(negedge clk) begin
    logic [10:0]   cur_out;
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    cur_out = {bus.dbg_state, bus.ch_rst_n_o, bus.busy_o, bus.run_o, bus.done_o, bus.timeout_o};
    if (cur_out !== prev_out) begin
      got = ev(cyc, cur_out[10:8], cur_out[7:4], cur_out[3], cur_out[2], cur_out[1], cur_out[0]);
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_change cyc=%0d got st/ch/b/r/d/t=%b required=no change", cyc, cur_out);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)  begin
          n_fail = n_fail + 1;
          $display("FAIL output_event got cyc=%0d st/ch/b/r/d/t=%b required cyc=%0d st/ch/b/r/d/t=%b",
                   cyc, cur_out, want[42:11], want[10:0]);
        end
      end
      prev_out = cur_out;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int c;
    int a;
    logic [9:0] async_out;
    bus.start_i   = 1'b0;
    bus.abort_i   = 1'b0;
    bus.kick_i    = 1'b0;
    bus.ch_mask_i = '0;

    // Reset state seen at the first sample.
    exp_q.push_back(ev(1, ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Full mask, start at cycle 10: bits rise 19/23/27/31, done at 35; abort from RUN.
    wait_until(10);
    do_start(4'b1111, t);
    push_full(t);
    wait_until(t + 30);
    do_abort();

    // Abort in the gap after ch1 lifts, then a full rerun.
    wait_until(cyc + 3);
    do_start(4'b1111, t);
    exp_q.push_back(ev(t + 1,  ST_HOLD, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 9,  ST_REL,  4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 13, ST_REL,  4'b0011, 1'b1, 1'b0, 1'b0, 1'b0));
    wait_until(t + 14);
    do_abort();
    wait_until(t + 20);
    do_start(4'b1111, t);
    push_full(t);
    wait_until(t + 30);
    do_abort();

    // Mask 1010: ch0 skipped (1 cycle), ch1 lifts at T+10, gap, ch2 skipped, ch3 at T+15,
    // gap, RUN at T+19. Mask change and a second start during HOLD are ignored.
    wait_until(cyc + 3);
    do_start(4'b1010, t);
    bus.ch_mask_i = 4'b0101;
    exp_q.push_back(ev(t + 1,  ST_HOLD, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 9,  ST_REL,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 10, ST_REL,  4'b0010, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 15, ST_REL,  4'b1010, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 19, ST_RUN,  4'b1010, 1'b0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(ev(t + 20, ST_RUN,  4'b1010, 1'b0, 1'b1, 1'b0, 1'b0));
    wait_until(t + 4);
    do_start(4'b1111, a);
    wait_until(t + 25);
    do_abort();

    // All-zero mask: four skip cycles, then RUN with no channel released.
    wait_until(cyc + 3);
    do_start(4'b0000, t);
    exp_q.push_back(ev(t + 1,  ST_HOLD, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 9,  ST_REL,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(t + 13, ST_RUN,  4'b0000, 1'b0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(ev(t + 14, ST_RUN,  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    wait_until(t + 20);
    do_abort();

`ifdef HARNESS_RSTSEQ_WDOG_EN
    // No kicks: RUN entered at C, timeout at C+20 with all channels back in reset.
    wait_until(cyc + 3);
    do_start(4'b1111, t);
    push_full(t);
    c = t + 25;
    exp_q.push_back(ev(c + 20, ST_TO, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_until(c + 22);

    // Restart from TIMEOUT clears the flag; a kick exactly on the zero count reloads.
    do_start(4'b1111, t);
    push_full(t);
    c = t + 25;
    wait_until(c + 19);
    do_kick();
    exp_q.push_back(ev(c + 40, ST_TO, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_until(c + 42);

    // Start and abort together in TIMEOUT: back to IDLE, no HOLD.
    exp_q.push_back(ev(cyc + 1, ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(posedge clk);
    #1 begin bus.start_i = 1'b0; bus.abort_i = 1'b0; end
    wait_until(cyc + 12);

    // Kicks every 15 cycles hold off the watchdog for over 500 cycles.
    do_start(4'b1111, t);
    push_full(t);
    c = t + 25;
    for (int i = 0; i < 34; i++) begin
      wait_until(c + 10 + 15 * i);
      do_kick();
    end
    wait_until(c + 510);
    do_abort();
`else
    // Without the watchdog RUN persists; start and kick in RUN are ignored.
    wait_until(cyc + 3);
    do_start(4'b1111, t);
    push_full(t);
    c = t + 25;
    wait_until(c + 5);
    do_start(4'b0000, a);
    do_kick();
    wait_until(c + 10000);
    do_abort();
`endif

    // rst_n dropped mid-RUN between edges: outputs clear without a clock.
    wait_until(cyc + 3);
    do_start(4'b1111, t);
    push_full(t);
    wait_until(t + 30);
    #2 rst_n = 1'b0;
    exp_q.push_back(ev(cyc + 1, ST_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    async_out = {bus.ch_rst_n_o, bus.cur_ch_o, bus.busy_o, bus.run_o, bus.done_o, bus.timeout_o};
    n_cmp = n_cmp + 1;
    if (async_out !== 10'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL async_reset got ch/cur/b/r/d/t=%b required=%b", async_out, 10'd0);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_until(cyc + 5);

    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
